stepper_pulse_gen: RTL and testbench

- Consumer end of the `direct`/`enable` motion-command interface driven by the turntable sequencing FSM.
- Converts the level commands into a step/direction/enable signal set for an external stepper driver.
- Applies a linear period ramp on acceleration and deceleration, and guarantees direction setup time before the first pulse.
- Reports motion status back to the sequencer.

---
 rtl/stepper_pulse_gen.sv | 258 +++++++++++++++++++++++++
 tb/tb_stepper_pulse_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : stepper_pulse_gen
//  Purpose  : Turns the level motion command (enable/direct) from the turntable
//             sequencer into step/direction/enable signals for an external
//             stepper driver. Applies a linear, clamped period ramp while
//             accelerating and decelerating, guarantees a direction setup
//             window before the first pulse and reports motion status.
//  Ports    : sclk      - system clock
//             s_rst_n   - synchronous active-low reset
//             enable    - motion request (1 = move)
//             direct    - requested direction (1 = clockwise), used only
//                         while enable=1
//             pul       - step pulse, PUL_W cycles high per step
//             dir       - direction to the driver
//             ena_n     - driver enable, active-low
//             busy      - high whenever the generator is not idle
//             at_speed  - high while cruising at PER_MIN
//             pos_clr   - (STEP_POS_EN only) synchronous clear of pos
//             pos       - (STEP_POS_EN only) signed step position, wraps
//  Options  : define STEP_POS_EN to build the step position counter.
//  Revision : 1.0 - initial release
// ============================================================================
module stepper_pulse_gen #(
    parameter int PER_MAX   = 50_000,
    parameter int PER_MIN   = 5_000,
    parameter int PER_STEP  = 500,
    parameter int PUL_W     = 100,
    parameter int SETUP_CYC = 500,
    parameter int CW        = 20
) (
    input  logic               sclk,
    input  logic               s_rst_n,
    input  logic               enable,
    input  logic               direct,
`ifdef STEP_POS_EN
    input  logic               pos_clr,
    output logic signed [31:0] pos,
`endif
    output logic               pul,
    output logic               dir,
    output logic               ena_n,
    output logic               busy,
    output logic               at_speed
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

    localparam logic [CW-1:0] c_PER_MAX  = CW'(PER_MAX);
    localparam logic [CW-1:0] c_PER_MIN  = CW'(PER_MIN);
    localparam logic [CW-1:0] c_PER_STEP = CW'(PER_STEP);
    localparam logic [CW-1:0] c_PUL_W    = CW'(PUL_W);
    localparam logic [CW-1:0] c_ONE      = CW'(1);

    // One bit wider so the clamp comparisons can never overflow
    localparam logic [CW:0]   c_PER_MAX_X  = (CW+1)'(PER_MAX);
    localparam logic [CW:0]   c_PER_MIN_X  = (CW+1)'(PER_MIN);
    localparam logic [CW:0]   c_PER_STEP_X = (CW+1)'(PER_STEP);

    localparam logic [SW-1:0] c_SETUP_LAST = SW'(SETUP_CYC - 1);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_SETUP  = 5'b00010,
        S_ACCEL  = 5'b00100,
        S_CRUISE = 5'b01000,
        S_DECEL  = 5'b10000
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          state_q,     state_d;
    logic [CW-1:0]   cur_per_q,   cur_per_d;
    logic [CW-1:0]   per_cnt_q,   per_cnt_d;
    logic [SW-1:0]   setup_cnt_q, setup_cnt_d;
    logic            dir_q,       dir_d;
    logic            ena_n_q,     ena_n_d;
    logic            pul_q,       pul_d;

    // ------------------------------------------------------------------------
    // Helper terms
    // ------------------------------------------------------------------------
    logic            w_last;      // step boundary cycle
    logic            w_rev;       // reversal requested while enabled
    logic            w_stop;      // stop or reverse request
    logic [CW-1:0]   w_ramp_dn;   // max(cur_per - PER_STEP, PER_MIN)
    logic [CW-1:0]   w_ramp_up;   // min(cur_per + PER_STEP, PER_MAX)
    logic [CW:0]     w_per_x;

    assign w_last  = (per_cnt_q == (cur_per_q - c_ONE));
    // Gated by enable so an undriven direct cannot leak in while disabled;
    // a simultaneous enable fall and direction change therefore reads as stop.
    assign w_rev   = enable && (direct != dir_q);
    assign w_stop  = !enable || w_rev;
    assign w_per_x = {1'b0, cur_per_q};

    // The subtraction / addition below only happens when the comparison has
    // already proven it stays inside [PER_MIN, PER_MAX], so nothing wraps.
    assign w_ramp_dn = (w_per_x >= (c_PER_MIN_X + c_PER_STEP_X))
                     ? (cur_per_q - c_PER_STEP) : c_PER_MIN;
    assign w_ramp_up = ((w_per_x + c_PER_STEP_X) >= c_PER_MAX_X)
                     ? c_PER_MAX : (cur_per_q + c_PER_STEP);

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cur_per_d   = cur_per_q;
        per_cnt_d   = per_cnt_q;
        setup_cnt_d = setup_cnt_q;
        dir_d       = dir_q;
        ena_n_d     = ena_n_q;
        pul_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                ena_n_d   = 1'b1;
                per_cnt_d = '0;
                cur_per_d = c_PER_MAX;
                if (enable) begin
                    dir_d       = direct;
                    ena_n_d     = 1'b0;
                    setup_cnt_d = '0;
                    state_d     = S_SETUP;
                end
            end

            S_SETUP: begin
                if (!enable) begin
                    ena_n_d = 1'b1;
                    state_d = S_IDLE;
                end else if (setup_cnt_q == c_SETUP_LAST) begin
                    per_cnt_d = '0;
                    cur_per_d = c_PER_MAX;
                    state_d   = S_ACCEL;
                end else begin
                    setup_cnt_d = setup_cnt_q + SW'(1);
                end
            end

            S_ACCEL, S_CRUISE, S_DECEL: begin
                // pul is registered, so the first pulse appears the cycle
                // after per_cnt returns to zero.
                pul_d     = (per_cnt_q < c_PUL_W);
                per_cnt_d = per_cnt_q + c_ONE;
                if (w_last) begin
                    per_cnt_d = '0;
                    case (state_q)
                        S_ACCEL: begin
                            if (w_stop) begin
                                state_d = S_DECEL;
                            end else begin
                                cur_per_d = w_ramp_dn;
                                if (w_ramp_dn == c_PER_MIN) begin
                                    state_d = S_CRUISE;
                                end
                            end
                        end
                        S_CRUISE: begin
                            cur_per_d = c_PER_MIN;
                            if (w_stop) begin
                                state_d = S_DECEL;
                            end
                        end
                        default: begin  // S_DECEL
                            if (enable && !w_rev) begin
                                // Request withdrawn: re-accelerate from here
                                state_d = S_ACCEL;
                            end else if (cur_per_q == c_PER_MAX) begin
                                if (!enable) begin
                                    ena_n_d = 1'b1;
                                    state_d = S_IDLE;
                                end else begin
                                    // Stopped at start speed: safe point to
                                    // turn around after a fresh setup window.
                                    dir_d       = direct;
                                    setup_cnt_d = '0;
                                    state_d     = S_SETUP;
                                end
                            end else begin
                                cur_per_d = w_ramp_up;
                            end
                        end
                    endcase
                end
            end

            default: begin
                ena_n_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            state_q     <= S_IDLE;
            cur_per_q   <= c_PER_MAX;
            per_cnt_q   <= '0;
            setup_cnt_q <= '0;
            dir_q       <= 1'b0;
            ena_n_q     <= 1'b1;
            pul_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_per_q   <= cur_per_d;
            per_cnt_q   <= per_cnt_d;
            setup_cnt_q <= setup_cnt_d;
            dir_q       <= dir_d;
            ena_n_q     <= ena_n_d;
            pul_q       <= pul_d;
        end
    end

    assign pul      = pul_q;
    assign dir      = dir_q;
    assign ena_n    = ena_n_q;
    assign busy     = (state_q != S_IDLE);
    assign at_speed = (state_q == S_CRUISE);

    // ------------------------------------------------------------------------
    // Optional step position counter
    // ------------------------------------------------------------------------
`ifdef STEP_POS_EN
    logic        w_step;
    logic [31:0] pos_q, pos_d;

    // Every boundary completes one step in the direction currently latched.
    assign w_step = ((state_q == S_ACCEL) || (state_q == S_CRUISE) ||
                     (state_q == S_DECEL)) && w_last;

    always_comb begin
        pos_d = pos_q;
        if (pos_clr) begin
            pos_d = '0;
        end else if (w_step) begin
            pos_d = dir_q ? (pos_q + 32'd1) : (pos_q - 32'd1);
        end
    end

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stepper_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stepper_pulse_gen
//  Purpose  : Directed bench for stepper_pulse_gen. Each scenario queues the
//             expected pulses (cycles since the previous pulse or since ena_n
//             fell, plus dir); a monitor checks every pulse rise against the
//             queue, and every pulse for width and stable dir.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stepper_pulse_gen;

    localparam int P_MAX   = 20;
    localparam int P_MIN   = 8;
    localparam int P_STEP  = 4;
    localparam int P_PUL_W = 2;
    localparam int P_SETUP = 5;
    localparam int P_CW    = 8;

    logic sclk    = 1'b0;
    logic s_rst_n = 1'b0;
    logic enable  = 1'b0;
    logic direct  = 1'b0;
    logic pul, dir, ena_n, busy, at_speed;
`ifdef STEP_POS_EN
    logic               pos_clr = 1'b0;
    logic signed [31:0] pos;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   gap;
        logic d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 sclk = ~sclk;

    stepper_pulse_gen #(
        .PER_MAX  (P_MAX),
        .PER_MIN  (P_MIN),
        .PER_STEP (P_STEP),
        .PUL_W    (P_PUL_W),
        .SETUP_CYC(P_SETUP),
        .CW       (P_CW)
    ) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .enable  (enable),
        .direct  (direct),
`ifdef STEP_POS_EN
        .pos_clr (pos_clr),
        .pos     (pos),
`endif
        .pul     (pul),
        .dir     (dir),
        .ena_n   (ena_n),
        .busy    (busy),
        .at_speed(at_speed)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int gap, input logic d);
        exp_t e;
        e.gap = gap;
        e.d   = d;
        exp_q.push_back(e);
    endtask

    task automatic push_list(input int gaps[], input logic d);
        foreach (gaps[i]) push(gaps[i], d);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sclk);
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return at_speed;
            1:       return busy;
            2:       return pul;
            default: return dir;
        endcase
    endfunction

    // Waits (sampling on negedges) until the selected output equals val.
    task automatic wait_out(input string name, input int which, input logic val, input int budget);
        bit hit = 0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge sclk);
            if (sel(which) === val) hit = 1;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got no change expected %0d within %0d cycles", name, val, budget);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    int   cyc        = 0;
    int   ref_cyc    = 0;
    int   rise_cyc   = 0;
    logic rise_dir   = 1'b0;
    logic prev_pul   = 1'b0;
    logic prev_ena_n = 1'b1;

    always @(negedge sclk) begin
        cyc++;
        if (prev_ena_n && !ena_n) ref_cyc = cyc;
        if (pul && !prev_pul) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_gap", cyc - ref_cyc, mon_e.gap);
                chk("pulse_dir", dir, mon_e.d);
            end
            ref_cyc  = cyc;
            rise_cyc = cyc;
            rise_dir = dir;
        end
        if (!pul && prev_pul && s_rst_n) begin
            chk("pulse_width", cyc - rise_cyc, P_PUL_W);
            chk("dir_stable", dir, rise_dir);
        end
        prev_pul   = pul;
        prev_ena_n = ena_n;
    end

    task automatic chk_idle(input string tag, input logic exp_dir);
        chk({tag, "_pul"},      pul,      1'b0);
        chk({tag, "_dir"},      dir,      exp_dir);
        chk({tag, "_ena_n"},    ena_n,    1'b1);
        chk({tag, "_busy"},     busy,     1'b0);
        chk({tag, "_at_speed"}, at_speed, 1'b0);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        // Reset state
        tick(3);
        chk_idle("reset", 1'b0);
`ifdef STEP_POS_EN
        chk("reset_pos", pos, 32'd0);
`endif
        s_rst_n = 1'b1;
        tick(2);

        // Start CW, ramp 20/16/12/8, stop as soon as cruising
        push_list('{6, 20, 16, 12, 8, 8, 12, 16}, 1'b1);
        enable = 1'b1;
        direct = 1'b1;
        tick(1);
        chk("start_ena_n", ena_n, 1'b0);
        chk("start_busy",  busy,  1'b1);
        chk("start_dir",   dir,   1'b1);
        wait_out("cruise1", 0, 1'b1, 200);
        enable = 1'b0;
        wait_out("stop1", 1, 1'b0, 300);
        chk_idle("stop1", 1'b1);
        chk("stop1_drained", exp_q.size(), 0);

        // Reverse at cruise: decel to 20, setup, re-accelerate CCW, stop
        push_list('{6, 20, 16, 12, 8, 8, 12, 16}, 1'b1);
        push_list('{25, 20, 16, 12, 8, 8, 12, 16}, 1'b0);
        enable = 1'b1;
        direct = 1'b1;
        wait_out("cruise2", 0, 1'b1, 200);
        direct = 1'b0;
        wait_out("rev_dir", 3, 1'b0, 300);
        chk("rev_pul",   pul,   1'b0);
        chk("rev_ena_n", ena_n, 1'b0);
        chk("rev_busy",  busy,  1'b1);
        wait_out("cruise3", 0, 1'b1, 300);
        enable = 1'b0;
        wait_out("stop2", 1, 1'b0, 300);
        chk_idle("stop2", 1'b0);

        // Abort during setup: no pulse may appear
        enable = 1'b1;
        direct = 1'b1;
        tick(1);
        chk("abort_setup_busy", busy, 1'b1);
        tick(2);
        enable = 1'b0;
        tick(3);
        chk_idle("abort", 1'b1);
        tick(40);

        // Stop while still accelerating; direct left undriven once disabled
        push_list('{6, 20}, 1'b0);
        enable = 1'b1;
        direct = 1'b0;
        wait_out("short_pul", 2, 1'b1, 50);
        enable = 1'b0;
        direct = 1'bx;
        wait_out("short_stop", 1, 1'b0, 100);
        chk_idle("short", 1'b0);
        tick(5);
        chk("short_still_idle", busy, 1'b0);

        // Withdrawn stop during decel: re-accelerate from the current period
        push_list('{6, 20, 16, 12, 8, 8, 8, 8, 8, 12, 16}, 1'b1);
        enable = 1'b1;
        direct = 1'b1;
        wait_out("cruise4", 0, 1'b1, 200);
        enable = 1'b0;
        wait_out("decel4", 0, 1'b0, 50);
        enable = 1'b1;
        chk("withdraw_busy", busy, 1'b1);
        wait_out("recruise4", 0, 1'b1, 50);
        enable = 1'b0;
        wait_out("stop4", 1, 1'b0, 300);
        chk_idle("stop4", 1'b1);

        // Reset in the middle of a pulse
        push(6, 1'b1);
        enable = 1'b1;
        direct = 1'b1;
        wait_out("rst_pul", 2, 1'b1, 50);
        s_rst_n = 1'b0;
        enable  = 1'b0;
        tick(1);
        chk_idle("midrst", 1'b0);
        tick(2);
        s_rst_n = 1'b1;
        tick(2);

`ifdef STEP_POS_EN
        pos_clr = 1'b1;
        tick(1);
        pos_clr = 1'b0;
        chk("pos_clr0", pos, 32'd0);
        // 10 CW steps
        push_list('{6, 20, 16, 12, 8, 8, 8, 8, 12, 16}, 1'b1);
        enable = 1'b1;
        direct = 1'b1;
        wait_out("pos_cruise", 0, 1'b1, 200);
        tick(16);
        enable = 1'b0;
        wait_out("pos_stop", 1, 1'b0, 300);
        chk("pos_cw10", pos, 32'd10);
        // 4 CCW steps as two short moves
        for (int r = 0; r < 2; r++) begin
            push_list('{6, 20}, 1'b0);
            enable = 1'b1;
            direct = 1'b0;
            wait_out("pos_short", 2, 1'b1, 50);
            enable = 1'b0;
            wait_out("pos_short_stop", 1, 1'b0, 100);
        end
        chk("pos_net6", pos, 32'd6);
        pos_clr = 1'b1;
        tick(1);
        pos_clr = 1'b0;
        chk("pos_clr", pos, 32'd0);
`endif

        tick(20);
        chk("final_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
